// File: rtl/switch_out_arbiter_if.sv
// Handshake bundle between the four input buffers, the output buffer and one output-port arbiter.
// The slave modport is the arbiter side; the master modport drives requests and flow control.
interface switch_out_arbiter_if #(
  parameter int LEN_W = 16
);
  logic [3:0]         req;
  logic [4*LEN_W-1:0] len_bus;
  logic [3:0]         word_vld;
  logic               out_ready;
  logic [3:0]         grant;
  logic [1:0]         sel;
  logic               busy;
  logic               pop;
  logic               eop;

  modport slave (
    input  req, len_bus, word_vld, out_ready,
    output grant, sel, busy, pop, eop
  );

  modport master (
    output req, len_bus, word_vld, out_ready,
    input  grant, sel, busy, pop, eop
  );
endinterface

// File: rtl/switch_out_arbiter.sv
// Round-robin packet arbiter for one switch output port; the grant is held for the whole packet.
// Define ARB_PKT_CNT_EN to add the CNT_W-bit completed-packet counter output pkt_cnt.
module switch_out_arbiter #(
  parameter int LEN_W = 16
`ifdef ARB_PKT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_out_arbiter_if.slave  bus
`ifdef ARB_PKT_CNT_EN
  , output logic [CNT_W-1:0]   pkt_cnt
`endif
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t       state_q, state_d;
  logic [3:0]   grant_q, grant_d;
  logic [1:0]   sel_q,   sel_d;
  logic [1:0]   ptr_q,   ptr_d;
  logic         busy_q,  busy_d;
  logic [LEN_W:0] rem_q, rem_d;

  logic         pick_vld;
  logic [1:0]   pick, idx;
  logic         pop, eop;

  assign pop = (state_q == XFER) && bus.word_vld[sel_q] && bus.out_ready;
  assign eop = pop && (rem_q == (LEN_W+1)'(1));

  // Scan ptr+1 .. ptr+4; the last-served input (ptr) is checked last.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 2'd0;
    idx      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = XFER;
          grant_d = 4'b0001 << pick;
          sel_d   = pick;
          busy_d  = 1'b1;
          // One extra bit so len = all-ones still yields the full word count.
          rem_d   = {1'b0, bus.len_bus[pick*LEN_W +: LEN_W]} + (LEN_W+1)'(1);
        end
      end
      XFER: begin
        if (pop) rem_d = rem_q - (LEN_W+1)'(1);
        if (eop) begin
          state_d = IDLE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
      busy_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;
  assign bus.pop   = pop;
  assign bus.eop   = eop;

`ifdef ARB_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (eop) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Randomized scoreboard bench: a packet-level reference model queues expected grants,
// a monitor checks grant/sel/pop/eop/busy (and pkt_cnt when enabled) against that queue.
module tb_switch_out_arbiter;
  localparam int LEN_W = 4;
`ifdef ARB_PKT_CNT_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] pkt_cnt;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  switch_out_arbiter_if #(.LEN_W(LEN_W)) bus ();

  switch_out_arbiter #(
    .LEN_W(LEN_W)
`ifdef ARB_PKT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  typedef struct {int src; int words;} pkt_t;
  pkt_t exp_q[$];
  pkt_t cur;

  int n_chk = 0, n_fail = 0;
  int m_busy = 0, m_cur = 0, m_rem = 0, m_last = 3;
  int in_pkt = 0, bubble = 0, wait_cnt = 0, cnt = 0, n_done = 0;

  logic [3:0] s_req = '0, s_vld = '0;
  logic       s_rdy = 1'b0, s_rst = 1'b0;
  int         s_len [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: whole packets granted round-robin, counted down by transfers.
  task automatic model();
    if (m_busy == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (s_req[j]) begin
          m_busy = 1; m_cur = j; m_rem = s_len[j] + 1;
          exp_q.push_back('{j, s_len[j] + 1});
          break;
        end
      end
    end else if (s_vld[m_cur] && s_rdy) begin
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_last = m_cur; end
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
    bus.req = s_req; bus.word_vld = s_vld; bus.out_ready = s_rdy;
    for (int i = 0; i < 4; i++) bus.len_bus[i*LEN_W +: LEN_W] = LEN_W'(s_len[i]);
    rst = s_rst;
    if (!s_rst) begin m_busy = 0; m_last = 3; exp_q.delete(); end
    else model();
  endtask

  task automatic drain();
    s_req = '0; s_vld = 4'hF; s_rdy = 1'b1;
    for (int i = 0; i < 40 && m_busy != 0; i++) step();
    repeat (3) step();
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    logic exp_pop;
    forever begin
      @(negedge clk); #4;
      if (!rst) begin
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_eop", bus.eop, 0);
`ifdef ARB_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt, 0);
`endif
        in_pkt = 0; bubble = 0; wait_cnt = 0; n_done = 0;
      end else begin
`ifdef ARB_PKT_CNT_EN
        chk("pkt_cnt", pkt_cnt, n_done % (1 << CNT_W));
`endif
        if (bubble != 0) begin
          chk("bubble_grant", bus.grant, 0);
          bubble = 0;
        end else if (in_pkt == 0 && bus.grant != 0) begin
          if (exp_q.size() == 0) chk("spurious_grant", bus.grant, 0);
          else begin
            cur = exp_q.pop_front();
            in_pkt = 1; cnt = 0; wait_cnt = 0;
            chk("grant_sel", bus.sel, cur.src);
          end
        end
        if (in_pkt != 0) begin
          exp_pop = bus.word_vld[cur.src] && bus.out_ready;
          chk("grant_onehot", bus.grant, 1 << cur.src);
          chk("busy", bus.busy, 1);
          chk("pop", bus.pop, exp_pop);
          chk("eop", bus.eop, exp_pop && (cnt + 1 == cur.words));
          if (exp_pop) cnt++;
          if (exp_pop && cnt == cur.words) begin in_pkt = 0; bubble = 1; n_done++; end
        end else begin
          chk("idle_busy", bus.busy, 0);
          chk("idle_pop", bus.pop, 0);
          chk("idle_eop", bus.eop, 0);
          if (exp_q.size() != 0) begin
            wait_cnt++;
            if (wait_cnt > 1) begin
              chk("grant_latency", bus.grant, 1 << exp_q[0].src);
              void'(exp_q.pop_front());
              wait_cnt = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    bus.req = '0; bus.word_vld = '0; bus.out_ready = 1'b0; bus.len_bus = '0;
    #12;
    chk("reset_grant", bus.grant, 0);
    chk("reset_sel", bus.sel, 0);
    chk("reset_busy", bus.busy, 0);
    s_rst = 1'b1;
    step();

    // All four requesting with single-word packets: 0,1,2,3,0 with bubbles.
    s_req = 4'hF; s_vld = 4'hF; s_rdy = 1'b1; s_len = '{0, 0, 0, 0};
    repeat (10) step();
    drain();

    // Lone requester, 6-word packet, then re-granted for a second packet.
    s_req = 4'b0001; s_len = '{5, 0, 0, 0};
    step();
    s_req = '0;
    repeat (8) step();
    s_req = 4'b0001;
    step();
    s_req = '0;
    repeat (3) step();
    // Abort mid-packet after 3 pops.
    s_rst = 1'b0;
    step();
    #1;
    chk("abort_grant", bus.grant, 0);
    chk("abort_busy", bus.busy, 0);
    step();
    s_rst = 1'b1; s_req = 4'hF; s_len = '{2, 1, 0, 3};
    step();
    repeat (6) step();
    drain();

    // Max length packet: no overflow of the word count.
    s_req = 4'b0100; s_len = '{0, 0, 15, 0};
    step();
    s_req = '0;
    drain();

    for (int n = 0; n < 2500; n++) begin
      s_req = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        s_len[i] = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4);
        s_vld[i] = ($urandom_range(0, 4) != 0);
      end
      s_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    chk("queue_empty", exp_q.size(), 0);
    chk("pkt_closed", in_pkt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
